// File: rtl/operand_load_ctrl.sv
// operand_load_ctrl: loads operand A, then operand B, from the switch bus.
// Each load is triggered by one press of an active-low push key.
// When both operands are held, the pair is offered downstream with valid/ack.
// Optional build macro DEBOUNCE_EN adds a DB_CYCLES stability filter on the key.
module operand_load_ctrl #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             ld_key,
  input  logic [WIDTH-1:0] din,
  input  logic             ack,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             a_ld,
  output logic             b_ld,
  output logic             valid,
  output logic [1:0]       state,
  output logic [7:0]       pair_cnt
);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t st;
  logic   k1, k2, k3;
  logic   sync_live;
  logic   rel_seen;
  logic   key_lvl;
  logic   press_c;

  // The debounce filter needs at least two cycles of stability to mean anything.
  if (DB_CYCLES < 2) begin : g_db_cycles_check
    $error("operand_load_ctrl: DB_CYCLES must be >= 2");
  end

  // Two-flop synchronizer on the raw key; the edge flop follows the filtered level.
  // sync_live marks k1 as holding a real sample (not its reset value), and
  // rel_seen arms the press detector only after the key has been seen released,
  // so a key held through reset cannot produce a press.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      k1        <= 1'b1;
      k2        <= 1'b1;
      k3        <= 1'b1;
      sync_live <= 1'b0;
      rel_seen  <= 1'b0;
    end else begin
      k1        <= ld_key;
      k2        <= k1;
      k3        <= key_lvl;
      sync_live <= 1'b1;
      rel_seen  <= rel_seen | (sync_live & k1);
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DBW = $clog2(DB_CYCLES);

  logic           kd;
  logic [DBW-1:0] dbc;

  // Accept a new key level only after it has differed from kd for DB_CYCLES cycles.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      kd  <= 1'b1;
      dbc <= '0;
    end else if (k2 == kd) begin
      dbc <= '0;
    end else if (dbc == DBW'(DB_CYCLES - 1)) begin
      kd  <= k2;
      dbc <= '0;
    end else begin
      dbc <= dbc + DBW'(1);
    end
  end

  assign key_lvl = kd;
`else
  assign key_lvl = k2;
`endif

  // One-cycle press on each 1->0 transition of the key level.
  assign press_c = k3 & ~key_lvl & rel_seen;

  // Load sequencer: A, then B, then hold the pair until ack.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      st       <= S_A;
      a_q      <= '0;
      b_q      <= '0;
      a_ld     <= 1'b0;
      b_ld     <= 1'b0;
      valid    <= 1'b0;
      pair_cnt <= '0;
    end else begin
      a_ld <= 1'b0;
      b_ld <= 1'b0;
      case (st)
        S_A: begin
          if (press_c) begin
            a_q  <= din;
            a_ld <= 1'b1;
            st   <= S_B;
          end
        end
        S_B: begin
          if (press_c) begin
            b_q   <= din;
            b_ld  <= 1'b1;
            valid <= 1'b1;
            st    <= S_FULL;
          end
        end
        S_FULL: begin
          // Presses here are dropped; ack wins even when both arrive together.
          if (ack) begin
            valid    <= 1'b0;
            pair_cnt <= pair_cnt + 8'd1;
            st       <= S_A;
          end
        end
        default: st <= S_A;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_operand_load_ctrl.sv
// tb_operand_load_ctrl: directed + randomized checks of operand_load_ctrl
// against a phase/count reference model.
module tb_operand_load_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DB    = 4;
`ifdef DEBOUNCE_EN
  localparam int unsigned LAT = DB + 3;
`else
  localparam int unsigned LAT = 3;
`endif

  logic             Clk = 1'b0;
  logic             Clr = 1'b1;
  logic             ld_key = 1'b1;
  logic [WIDTH-1:0] din = '0;
  logic             ack = 1'b0;
  logic [WIDTH-1:0] a_q, b_q;
  logic             a_ld, b_ld, valid;
  logic [1:0]       state;
  logic [7:0]       pair_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: which operand is next (0 = A, 1 = B, 2 = pair held).
  int               m_phase = 0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  int               m_cnt = 0;

  operand_load_ctrl #(.WIDTH(WIDTH), .DB_CYCLES(DB)) dut (
    .Clk(Clk), .Clr(Clr), .ld_key(ld_key), .din(din), .ack(ack),
    .a_q(a_q), .b_q(b_q), .a_ld(a_ld), .b_ld(b_ld), .valid(valid),
    .state(state), .pair_cnt(pair_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_a_ld, input bit exp_b_ld);
    chk({tag, ".a_ld"}, 32'(a_ld), 32'(exp_a_ld));
    chk({tag, ".b_ld"}, 32'(b_ld), 32'(exp_b_ld));
    chk({tag, ".a_q"}, 32'(a_q), 32'(m_a));
    chk({tag, ".b_q"}, 32'(b_q), 32'(m_b));
    chk({tag, ".valid"}, 32'(valid), 32'(m_phase == 2));
    chk({tag, ".state"}, 32'(state), 32'(m_phase));
    chk({tag, ".pair_cnt"}, 32'(pair_cnt), 32'(m_cnt % 256));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_a     = '0;
    m_b     = '0;
    m_cnt   = 0;
  endtask

  // One key press; optional ack raised for exactly the capture edge.
  task automatic press(input logic [WIDTH-1:0] d, input bit with_ack);
    int  hold;
    bit  exp_a, exp_b;
    hold  = int'(LAT) + int'($urandom_range(0, 3));
    exp_a = 1'b0;
    exp_b = 1'b0;
    din    = d;
    ld_key = 1'b0;
    for (int i = 0; i < int'(LAT) - 1; i++) begin
      tick();
      chk("pre_capture.a_ld", 32'(a_ld), 32'd0);
      chk("pre_capture.b_ld", 32'(b_ld), 32'd0);
    end
    if (with_ack) ack = 1'b1;
    tick();
    ack = 1'b0;
    if (m_phase == 0) begin
      m_a = d; m_phase = 1; exp_a = 1'b1;
    end else if (m_phase == 1) begin
      m_b = d; m_phase = 2; exp_b = 1'b1;
    end else if (with_ack) begin
      m_phase = 0; m_cnt++;
    end
    chk_all("capture", exp_a, exp_b);
    din = WIDTH'($urandom);
    for (int i = 0; i < hold - int'(LAT); i++) tick();
    ld_key = 1'b1;
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      tick();
      chk("release.a_ld", 32'(a_ld), 32'd0);
      chk("release.b_ld", 32'(b_ld), 32'd0);
    end
    chk_all("after_release", 1'b0, 1'b0);
  endtask

  task automatic ack_step();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    if (m_phase == 2) begin
      m_phase = 0;
      m_cnt++;
    end
    chk_all("ack", 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then idle.
    Clr = 1'b1;
    tick();
    tick();
    Clr = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("idle", 1'b0, 1'b0);
    end

    // Two presses fill the pair.
    press(16'h1234, 1'b0);
    press(16'hABCD, 1'b0);
    chk("full.valid", 32'(valid), 32'd1);
    chk("full.state", 32'(state), 32'd2);

    // Press while full is dropped; then ack releases the pair.
    press(16'h5555, 1'b0);
    chk("drop.a_q", 32'(a_q), 32'h1234);
    ack_step();
    chk("ack.pair_cnt", 32'(pair_cnt), 32'd1);
    chk("ack.a_q_kept", 32'(a_q), 32'h1234);

    // Ack outside S_FULL is ignored.
    ack_step();

    // Simultaneous press and ack in S_FULL: ack wins, press dropped.
    press(WIDTH'($urandom), 1'b0);
    press(WIDTH'($urandom), 1'b0);
    press(16'h7777, 1'b1);
    chk("press_ack.state", 32'(state), 32'd0);
    chk("press_ack.pair_cnt", 32'(pair_cnt), 32'd2);

`ifdef DEBOUNCE_EN
    // Short glitch is filtered out.
    din    = 16'h0BAD;
    ld_key = 1'b0;
    tick();
    tick();
    ld_key = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_all("glitch", 1'b0, 1'b0);
    end
`endif

    // Reset mid-pair with the key held low through and after reset.
    press(16'h00FF, 1'b0);
    ld_key = 1'b0;
    tick();
    Clr = 1'b1;
    tick();
    tick();
    Clr = 1'b0;
    model_reset();
    chk_all("mid_reset", 1'b0, 1'b0);
    for (int i = 0; i < int'(LAT) + 6; i++) begin
      tick();
      chk_all("held_after_reset", 1'b0, 1'b0);
    end
    ld_key = 1'b1;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      tick();
      chk_all("release_after_reset", 1'b0, 1'b0);
    end
    press(16'h4242, 1'b0);
    chk("fresh_press.a_q", 32'(a_q), 32'h4242);
    press(WIDTH'($urandom), 1'b0);
    ack_step();

    // Randomized pairs; 1 + 255 pairs after reset brings pair_cnt back to 0.
    for (int p = 0; p < 255; p++) begin
      if ($urandom_range(0, 3) == 0) ack_step();
      press(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      press(WIDTH'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) press(WIDTH'($urandom), 1'b0);
      ack_step();
    end
    chk("wrap.pair_cnt", 32'(pair_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
